// File: rtl/video_pkg.sv
// Shared timing constants, count type and window-compare helper for the video timing generator.
package video_pkg;

    localparam int H_VISIBLE   = 256;
    localparam int V_VIS_START = 16;
    localparam int V_VIS_END   = 240;
    localparam int HS_START    = 304;
    localparam int HS_WIDTH    = 32;
    localparam int VS_START    = 248;
    localparam int VS_WIDTH    = 4;

    typedef logic [8:0] count_t;

    // True when pos lies in [start+offs, start+offs+width-1]; 10-bit signed math keeps shifted bounds from wrapping.
    function automatic logic in_window(input count_t pos, input logic [3:0] offs,
                                       input int start, input int width);
        logic signed [9:0] p;
        logic signed [9:0] lo;
        logic signed [9:0] hi;
        p  = $signed({1'b0, pos});
        lo = $signed(10'(start)) + $signed({{6{offs[3]}}, offs});
        hi = lo + $signed(10'(width - 1));
        return (p >= lo) && (p <= hi);
    endfunction

endpackage

// File: rtl/ce_divider.sv
// Divides clk_sys down to a one-cycle pixel clock enable.
module ce_divider #(
    parameter int CE_DIV = 8
) (
    input  logic clk_sys,
    input  logic reset_n,
    output logic ce_pix
);

    localparam logic [3:0] DIV_LAST = 4'(CE_DIV - 1);

    logic [3:0] div_q;
    logic [3:0] div_d;

    always_comb begin
        div_d = div_q + 4'd1;
        if (div_q == DIV_LAST) begin
            div_d = 4'd0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= 4'd0;
        end else begin
            div_q <= div_d;
        end
    end

    assign ce_pix = (div_q == DIV_LAST);

endmodule

// File: rtl/video_timing.sv
// Raster counters, blanking, offsettable syncs and a frame pulse, all advancing on the pixel enable.
module video_timing
    import video_pkg::*;
#(
    parameter int CE_DIV  = 8,
    parameter int H_TOTAL = 384,
    parameter int V_TOTAL = 264
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic [3:0] hoffs,
    input  logic [3:0] voffs,
    output logic       ce_pix,
    output logic [8:0] hcount,
    output logic [8:0] vcount,
    output logic       hb,
    output logic       vb,
    output logic       hs,
    output logic       vs,
    output logic       frame
);

    localparam count_t H_LAST  = 9'(H_TOTAL - 1);
    localparam count_t V_LAST  = 9'(V_TOTAL - 1);
    localparam count_t V_FRAME = 9'(V_VIS_END - 1);

    count_t     hcount_q, hcount_d;
    count_t     vcount_q, vcount_d;
    logic       hb_q, hb_d;
    logic       vb_q, vb_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic [3:0] hoffs_q, hoffs_d;
    logic [3:0] voffs_q, voffs_d;
    logic       h_last;
    logic       v_last;

    ce_divider #(.CE_DIV(CE_DIV)) u_ce_divider (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .ce_pix  (ce_pix)
    );

    assign h_last = (hcount_q == H_LAST);
    assign v_last = (vcount_q == V_LAST);

    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        hb_d     = hb_q;
        vb_d     = vb_q;
        hs_d     = hs_q;
        vs_d     = vs_q;
        hoffs_d  = hoffs_q;
        voffs_d  = voffs_q;
        if (ce_pix) begin
            hcount_d = h_last ? 9'd0 : hcount_q + 9'd1;
            if (h_last) begin
                vcount_d = v_last ? 9'd0 : vcount_q + 9'd1;
            end
            // Offsets only move at the frame boundary so a frame never tears.
            if (h_last && v_last) begin
                hoffs_d = hoffs;
                voffs_d = voffs;
            end
            // Decoded from the next count so outputs line up with the counter they describe.
            hb_d = (hcount_d >= 9'(H_VISIBLE));
            vb_d = (vcount_d < 9'(V_VIS_START)) || (vcount_d >= 9'(V_VIS_END));
            hs_d = in_window(hcount_d, hoffs_d, HS_START, HS_WIDTH);
            vs_d = in_window(vcount_d, voffs_d, VS_START, VS_WIDTH);
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hcount_q <= 9'd0;
            vcount_q <= 9'd0;
            hb_q     <= 1'b0;
            vb_q     <= 1'b1;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            hoffs_q  <= 4'd0;
            voffs_q  <= 4'd0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hb_q     <= hb_d;
            vb_q     <= vb_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            hoffs_q  <= hoffs_d;
            voffs_q  <= voffs_d;
        end
    end

    assign hcount = hcount_q;
    assign vcount = vcount_q;
    assign hb     = hb_q;
    assign vb     = vb_q;
    assign hs     = hs_q;
    assign vs     = vs_q;
    // The frame pulse is the enable cycle that carries the counters onto hcount=0, vcount=240.
    assign frame  = ce_pix && h_last && (vcount_q == V_FRAME);

endmodule

// File: tb/tb_video_timing.sv
// Directed bench for video_timing: four builds share one clock, reduced raster sizes keep frame-level checks short.
module tb_video_timing;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Instance map: 0 defaults, 1 CE_DIV=2 H=384 V=4, 2 CE_DIV=2 H=8 V=264, 3 CE_DIV=4 H=8 V=264.
    logic       rst_a  [4];
    logic [3:0] hoff_a [4];
    logic [3:0] voff_a [4];
    logic       ce_a   [4];
    logic [8:0] hc_a   [4];
    logic [8:0] vc_a   [4];
    logic       hb_a   [4];
    logic       vb_a   [4];
    logic       hs_a   [4];
    logic       vs_a   [4];
    logic       fr_a   [4];

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [23:0] RESET_VEC = {1'b0, 9'd0, 9'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    video_timing #(.CE_DIV(8), .H_TOTAL(384), .V_TOTAL(264)) dut_d (
        .clk_sys(clk_sys), .reset_n(rst_a[0]), .hoffs(hoff_a[0]), .voffs(voff_a[0]),
        .ce_pix(ce_a[0]), .hcount(hc_a[0]), .vcount(vc_a[0]), .hb(hb_a[0]), .vb(vb_a[0]),
        .hs(hs_a[0]), .vs(vs_a[0]), .frame(fr_a[0]));

    video_timing #(.CE_DIV(2), .H_TOTAL(384), .V_TOTAL(4)) dut_h (
        .clk_sys(clk_sys), .reset_n(rst_a[1]), .hoffs(hoff_a[1]), .voffs(voff_a[1]),
        .ce_pix(ce_a[1]), .hcount(hc_a[1]), .vcount(vc_a[1]), .hb(hb_a[1]), .vb(vb_a[1]),
        .hs(hs_a[1]), .vs(vs_a[1]), .frame(fr_a[1]));

    video_timing #(.CE_DIV(2), .H_TOTAL(8), .V_TOTAL(264)) dut_v (
        .clk_sys(clk_sys), .reset_n(rst_a[2]), .hoffs(hoff_a[2]), .voffs(voff_a[2]),
        .ce_pix(ce_a[2]), .hcount(hc_a[2]), .vcount(vc_a[2]), .hb(hb_a[2]), .vb(vb_a[2]),
        .hs(hs_a[2]), .vs(vs_a[2]), .frame(fr_a[2]));

    video_timing #(.CE_DIV(4), .H_TOTAL(8), .V_TOTAL(264)) dut_4 (
        .clk_sys(clk_sys), .reset_n(rst_a[3]), .hoffs(hoff_a[3]), .voffs(voff_a[3]),
        .ce_pix(ce_a[3]), .hcount(hc_a[3]), .vcount(vc_a[3]), .hb(hb_a[3]), .vb(vb_a[3]),
        .hs(hs_a[3]), .vs(vs_a[3]), .frame(fr_a[3]));

    task automatic next_pix(input int idx);
        int n;
        n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (ce_a[idx] !== 1'b1 && n < 40);
    endtask

    // Stops on a negedge where ce is high and the counters sit at (h, v); -1 matches anything.
    task automatic wait_pos(input int idx, input int h, input int v, input int limit, input string what);
        int n;
        bit hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < limit) begin
            @(negedge clk_sys);
            n++;
            hit = (ce_a[idx] === 1'b1) && (h < 0 || int'(hc_a[idx]) == h) && (v < 0 || int'(vc_a[idx]) == v);
        end
        if (!hit) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: position (%0d,%0d) not reached within %0d cycles", what, h, v, limit);
        end
    endtask

    task automatic measure_line(input int idx, input int htot,
                                output int first, output int last, output int cnt, output int hb_first);
        first = -1; last = -1; cnt = 0; hb_first = -1;
        for (int p = 0; p < htot; p++) begin
            if (hs_a[idx] === 1'b1) begin
                if (first < 0) first = int'(hc_a[idx]);
                last = int'(hc_a[idx]);
                cnt++;
            end
            if (hb_a[idx] === 1'b1 && hb_first < 0) hb_first = int'(hc_a[idx]);
            next_pix(idx);
        end
    endtask

    task automatic measure_frame(input int idx, input int htot, input int vtot,
                                 output int vs_first, output int vs_last, output int vs_cnt,
                                 output int vis_first, output int vis_last);
        vs_first = -1; vs_last = -1; vs_cnt = 0; vis_first = -1; vis_last = -1;
        for (int l = 0; l < vtot; l++) begin
            if (vs_a[idx] === 1'b1) begin
                if (vs_first < 0) vs_first = int'(vc_a[idx]);
                vs_last = int'(vc_a[idx]);
                vs_cnt++;
            end
            if (vb_a[idx] === 1'b0) begin
                if (vis_first < 0) vis_first = int'(vc_a[idx]);
                vis_last = int'(vc_a[idx]);
            end
            for (int p = 0; p < htot; p++) next_pix(idx);
        end
    endtask

    task automatic test_reset();
        int edges;
        logic ce_at7;
        int n_ce;
        repeat (3) @(negedge clk_sys);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({ce_a[i], hc_a[i], vc_a[i], hb_a[i], vb_a[i], hs_a[i], vs_a[i], fr_a[i]} !== RESET_VEC) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: got %h expected %h", i,
                         {ce_a[i], hc_a[i], vc_a[i], hb_a[i], vb_a[i], hs_a[i], vs_a[i], fr_a[i]}, RESET_VEC);
            end
        end
        rst_a[0] = 1'b1;
        edges = 0;
        ce_at7 = 1'b0;
        while (hc_a[0] == 9'd0 && edges < 40) begin
            @(posedge clk_sys);
            #1;
            edges++;
            if (edges == 7) ce_at7 = ce_a[0];
        end
        n_checks++;
        if (edges != 8) begin
            n_fail++;
            $display("FAIL first_ce_edge: got %0d expected 8", edges);
        end
        n_checks++;
        if (ce_at7 !== 1'b1) begin
            n_fail++;
            $display("FAIL ce_after_7_edges: got %b expected 1", ce_at7);
        end
        n_ce = 0;
        for (int c = 0; c < 3072; c++) begin
            @(negedge clk_sys);
            if (ce_a[0] === 1'b1) n_ce++;
        end
        n_checks++;
        if (n_ce != 384) begin
            n_fail++;
            $display("FAIL ce_per_line: got %0d expected 384", n_ce);
        end
        @(posedge clk_sys);
        #1;
        n_checks++;
        if (hc_a[0] !== 9'd1 || vc_a[0] !== 9'd1) begin
            n_fail++;
            $display("FAIL line_wrap: got h=%0d v=%0d expected h=1 v=1", hc_a[0], vc_a[0]);
        end
    endtask

    task automatic test_horizontal();
        int first, last, cnt, hbf;
        @(negedge clk_sys);
        hoff_a[1] = 4'd0;
        rst_a[1] = 1'b1;
        wait_pos(1, 0, 0, 10, "h_start");
        measure_line(1, 384, first, last, cnt, hbf);
        n_checks++;
        if (first != 304 || last != 335 || cnt != 32) begin
            n_fail++;
            $display("FAIL hs_default: got %0d..%0d (%0d) expected 304..335 (32)", first, last, cnt);
        end
        n_checks++;
        if (hbf != 256) begin
            n_fail++;
            $display("FAIL hb_rise: got %0d expected 256", hbf);
        end
        hoff_a[1] = 4'b1000;
        wait_pos(1, 0, 0, 4000, "h_frame_neg8");
        measure_line(1, 384, first, last, cnt, hbf);
        n_checks++;
        if (first != 296 || last != 327 || cnt != 32) begin
            n_fail++;
            $display("FAIL hs_minus8: got %0d..%0d (%0d) expected 296..327 (32)", first, last, cnt);
        end
        hoff_a[1] = 4'b0111;
        wait_pos(1, 0, 0, 4000, "h_frame_pos7");
        measure_line(1, 384, first, last, cnt, hbf);
        n_checks++;
        if (first != 311 || last != 342 || cnt != 32) begin
            n_fail++;
            $display("FAIL hs_plus7: got %0d..%0d (%0d) expected 311..342 (32)", first, last, cnt);
        end
        hoff_a[1] = 4'd0;
        wait_pos(1, 0, 0, 4000, "h_frame_zero");
        wait_pos(1, 0, 1, 1000, "h_line1");
        hoff_a[1] = 4'd3;
        for (int l = 1; l < 4; l++) begin
            measure_line(1, 384, first, last, cnt, hbf);
            n_checks++;
            if (first != 304 || last != 335) begin
                n_fail++;
                $display("FAIL hs_hold_line%0d: got %0d..%0d expected 304..335", l, first, last);
            end
        end
        n_checks++;
        if (vc_a[1] !== 9'd0) begin
            n_fail++;
            $display("FAIL next_frame_line: got %0d expected 0", vc_a[1]);
        end
        measure_line(1, 384, first, last, cnt, hbf);
        n_checks++;
        if (first != 307 || last != 338 || cnt != 32) begin
            n_fail++;
            $display("FAIL hs_plus3: got %0d..%0d (%0d) expected 307..338 (32)", first, last, cnt);
        end
    endtask

    task automatic test_vertical();
        int vf, vl, vn, sf, sl;
        int n;
        @(negedge clk_sys);
        voff_a[2] = 4'd0;
        rst_a[2] = 1'b1;
        wait_pos(2, 0, 0, 10, "v_start");
        measure_frame(2, 8, 264, vf, vl, vn, sf, sl);
        n_checks++;
        if (vf != 248 || vl != 251 || vn != 4) begin
            n_fail++;
            $display("FAIL vs_default: got %0d..%0d (%0d) expected 248..251 (4)", vf, vl, vn);
        end
        n_checks++;
        if (sf != 16 || sl != 239) begin
            n_fail++;
            $display("FAIL vb_visible: got %0d..%0d expected 16..239", sf, sl);
        end
        voff_a[2] = 4'b1000;
        wait_pos(2, 0, 0, 5000, "v_frame_neg8");
        measure_frame(2, 8, 264, vf, vl, vn, sf, sl);
        n_checks++;
        if (vf != 240 || vl != 243 || vn != 4) begin
            n_fail++;
            $display("FAIL vs_minus8: got %0d..%0d (%0d) expected 240..243 (4)", vf, vl, vn);
        end
        n = 0;
        while (fr_a[2] !== 1'b1 && n < 5000) begin
            @(negedge clk_sys);
            n++;
        end
        n_checks++;
        if (fr_a[2] !== 1'b1 || hc_a[2] !== 9'd7 || vc_a[2] !== 9'd239) begin
            n_fail++;
            $display("FAIL frame_pos: got fr=%b h=%0d v=%0d expected fr=1 h=7 v=239", fr_a[2], hc_a[2], vc_a[2]);
        end
        @(posedge clk_sys);
        #1;
        n_checks++;
        if (hc_a[2] !== 9'd0 || vc_a[2] !== 9'd240 || fr_a[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_after: got h=%0d v=%0d fr=%b expected h=0 v=240 fr=0", hc_a[2], vc_a[2], fr_a[2]);
        end
        n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (fr_a[2] !== 1'b1 && n < 5000);
        n_checks++;
        if (n != 4224) begin
            n_fail++;
            $display("FAIL frame_period_div2: got %0d expected 4224", n);
        end
    endtask

    task automatic test_ce_div4();
        int n_ce, n;
        @(negedge clk_sys);
        rst_a[3] = 1'b1;
        n_ce = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk_sys);
            if (ce_a[3] === 1'b1) n_ce++;
        end
        n_checks++;
        if (n_ce != 100) begin
            n_fail++;
            $display("FAIL ce_duty_div4: got %0d of 400 expected 100", n_ce);
        end
        n = 0;
        while (fr_a[3] !== 1'b1 && n < 9000) begin
            @(negedge clk_sys);
            n++;
        end
        n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (fr_a[3] !== 1'b1 && n < 9000);
        n_checks++;
        if (n != 8448) begin
            n_fail++;
            $display("FAIL frame_period_div4: got %0d expected 8448", n);
        end
    endtask

    task automatic test_async_reset();
        int edges;
        wait_pos(0, 200, -1, 4000, "async_h200");
        #2;
        rst_a[0] = 1'b0;
        #1;
        n_checks++;
        if ({ce_a[0], hc_a[0], vc_a[0], hb_a[0], vb_a[0], hs_a[0], vs_a[0], fr_a[0]} !== RESET_VEC) begin
            n_fail++;
            $display("FAIL async_reset_d: got %h expected %h",
                     {ce_a[0], hc_a[0], vc_a[0], hb_a[0], vb_a[0], hs_a[0], vs_a[0], fr_a[0]}, RESET_VEC);
        end
        wait_pos(2, 5, 150, 5000, "async_v150");
        #2;
        rst_a[2] = 1'b0;
        #1;
        n_checks++;
        if ({ce_a[2], hc_a[2], vc_a[2], hb_a[2], vb_a[2], hs_a[2], vs_a[2], fr_a[2]} !== RESET_VEC) begin
            n_fail++;
            $display("FAIL async_reset_v: got %h expected %h",
                     {ce_a[2], hc_a[2], vc_a[2], hb_a[2], vb_a[2], hs_a[2], vs_a[2], fr_a[2]}, RESET_VEC);
        end
        @(negedge clk_sys);
        rst_a[0] = 1'b1;
        edges = 0;
        while (hc_a[0] == 9'd0 && edges < 40) begin
            @(posedge clk_sys);
            #1;
            edges++;
        end
        n_checks++;
        if (edges != 8) begin
            n_fail++;
            $display("FAIL restart_d: got %0d edges expected 8", edges);
        end
        @(negedge clk_sys);
        rst_a[2] = 1'b1;
        edges = 0;
        while (hc_a[2] == 9'd0 && edges < 40) begin
            @(posedge clk_sys);
            #1;
            edges++;
        end
        n_checks++;
        if (edges != 2 || vc_a[2] !== 9'd0) begin
            n_fail++;
            $display("FAIL restart_v: got %0d edges v=%0d expected 2 edges v=0", edges, vc_a[2]);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            rst_a[i]  = 1'b0;
            hoff_a[i] = 4'd0;
            voff_a[i] = 4'd0;
        end
        test_reset();
        test_horizontal();
        fork
            test_vertical();
            test_ce_div4();
        join
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
